single_cycle_cpu: RTL and testbench
===================================

// Module: single_cycle_cpu
// PURPOSE
//   Single-cycle 32-bit MIPS-subset processor: each instruction is fetched, decoded, executed,
//   and retired in one clk cycle. Top-level core of the CPU lab design. Instruction and data
//   memories are internal and word-addressed. Register file and memories are preloaded
//   hierarchically by benches.
// PARAMETERS
//   IMEM_DEPTH  256  instruction memory depth, 32-bit words (power of two)
//   DMEM_DEPTH  256  data memory depth, 32-bit words (power of two)
//   RESET_PC    0    PC value after reset (word address)
// PORTS
//   clk  input  1  single clock; all state updates on rising edge
//   rst  input  1  reset, synchronous, active-high
// BEHAVIOUR
// - Reset: rst=1 at a rising edge loads PC<=RESET_PC; no register or memory write that cycle.
//   Register file and memories are never cleared, so preloaded contents survive reset.
// - Word addressing throughout:
//   - PC indexes imem directly; next sequential PC = PC+1.
//   - Memory index = low log2(depth) bits of the address; upper bits ignored (wrap).
// - Decode fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0] imm16 sign-extended.
// - Supported instructions:
//   - R-type (op=0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed);
//     rd <= rs OP rt.
//   - lw 0x23:   rt <= dmem[rs+simm].
//   - sw 0x2B:   dmem[rs+simm] <= rt.
//   - addi 0x08: rt <= rs+simm.
//   - beq 0x04:  if rs==rt, PC <= PC+1+simm, else PC+1.
//   - bne 0x05:  if rs!=rt, PC <= PC+1+simm, else PC+1.
//   - j 0x02:    PC <= {PC[31:26], instr[25:0]}.
// - Arithmetic is 32-bit two's complement, wraps, no overflow trap.
// - Any other opcode or funct acts as a NOP: PC <= PC+1, no writes.
// - Reads are combinational: imem, both regfile read ports, and dmem.
// - Writes occur at the rising edge: regfile write, dmem write, PC update.
// - $0 always reads 0; writes to $0 are discarded.
// - A same-cycle read of the register being written returns the old value.
// - Branch offset -1 targets the branch itself: a taken branch loops forever at that PC.
// STRUCTURE
// - Shared package cpu_pkg holds:
//   - opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J,
//     FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT)
//   - ALU op enum
//   - control-signal struct: reg_dst, alu_src, mem_to_reg, reg_write, mem_write,
//     branch_eq, branch_ne, jump
// - Required sub-module instances, with these exact names, for hierarchical preload:
//   - regFile: reg_file; 32x32 array named `registers`; 2 read ports, 1 write port.
//   - imem: inst_mem; IMEM_DEPTH x 32 array named `memory`; read-only in RTL.
//   - dmem: data_mem; DMEM_DEPTH x 32 array named `memory`; synchronous write, async read.
// - Decode/control and ALU are combinational logic inside the top.
// TESTING
// - rst=1 for one edge, then release -> PC=0; preloaded registers unchanged.
// - imem[0]=AC030040 (sw $3,64($0)), $3=0x1234 -> after one cycle dmem[64]=0x1234 and PC=1.
// - imem[1]=8C240002 (lw $4,2($1)), $1=5, dmem[7]=0xCAFE -> after one cycle $4=0xCAFE and PC=2.
// - imem[2]=00A63820 (add $7,$5,$6), $5=3, $6=0xFFFFFFFF -> $7=2;
//   also sub/slt: slt(-1,3) = 1.
// - imem[3]=1509FFFF (bne $8,$9,-1):
//   - $8!=$9 -> PC stays 3 every cycle;
//   - $8==$9 -> PC=4.
// - imem[4]=1109FFFF (beq $8,$9,-1):
//   - equal -> PC stays 4;
//   - else PC=5.
//   imem[5]=08000002 (j 2) -> PC=2.
//   Also: add writing $0 -> $0 still 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode/funct encodings, ALU operation enum and decoded control bundle
// for the single-cycle MIPS-subset core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_write;
    logic branch_eq;
    logic branch_ne;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM with asynchronous read and rising-edge write.
module data_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);

  logic [31:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) memory[addr_i] <= wd_i;
  end

  assign rd_o = memory[addr_i];

endmodule

// File: rtl/inst_mem.sv
// Word-addressed instruction ROM, contents loaded from outside the RTL.
module inst_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   data_o
);

  logic [31:0] memory [DEPTH];

  assign data_o = memory[addr_i];

endmodule

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one clocked write port.
// $0 reads as zero and ignores writes.
module reg_file (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] registers [32];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) registers[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : registers[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : registers[ra2_i];

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset core: fetch, decode, execute and retire in one clock.
// Decode/control and ALU live here; storage is in the three sub-modules.
module single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr, rs_val, rt_val, dmem_rdata;
  logic [31:0] simm, alu_b, alu_y, wb_data, pc_plus1;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic        rs_eq_rt, take_branch;
  ctrl_t       ctrl;
  alu_op_e     alu_op;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign simm  = {{16{instr[15]}}, instr[15:0]};

  inst_mem #(.DEPTH(IMEM_DEPTH)) imem (
    .addr_i (pc_q[IAW-1:0]),
    .data_o (instr)
  );

  reg_file regFile (
    .clk   (clk),
    .we_i  (ctrl.reg_write && !rst),
    .ra1_i (rs),
    .ra2_i (rt),
    .wa_i  (wa),
    .wd_i  (wb_data),
    .rd1_o (rs_val),
    .rd2_o (rt_val)
  );

  data_mem #(.DEPTH(DMEM_DEPTH)) dmem (
    .clk    (clk),
    .we_i   (ctrl.mem_write && !rst),
    .addr_i (alu_y[DAW-1:0]),
    .wd_i   (rt_val),
    .rd_o   (dmem_rdata)
  );

  // Unrecognised opcodes and functs leave ctrl all-zero, which is a NOP.
  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    unique case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        unique case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ:  ctrl.branch_eq = 1'b1;
      OP_BNE:  ctrl.branch_ne = 1'b1;
      OP_J:    ctrl.jump      = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = ctrl.alu_src ? simm : rt_val;

  always_comb begin
    alu_y = 32'd0;
    unique case (alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
  end

  assign wa      = ctrl.reg_dst ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? dmem_rdata : alu_y;

  assign rs_eq_rt    = (rs_val == rt_val);
  assign take_branch = (ctrl.branch_eq && rs_eq_rt) || (ctrl.branch_ne && !rs_eq_rt);
  assign pc_plus1    = pc_q + 32'd1;

  always_comb begin
    pc_d = pc_plus1;
    if (ctrl.jump)       pc_d = {pc_q[31:26], instr[25:0]};
    else if (take_branch) pc_d = pc_plus1 + simm;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Scoreboard bench for single_cycle_cpu: each step queues the architectural
// state it expects, clocks once, then pops and compares against the core.
module tb_single_cycle_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;

  single_cycle_cpu dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  typedef enum int {K_PC, K_REG, K_MEM} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic logic [31:0] observe(kind_e k, int idx);
    case (k)
      K_PC:    return dut.pc_q;
      K_REG:   return dut.regFile.registers[idx];
      default: return dut.dmem.memory[idx];
    endcase
  endfunction

  task automatic push(string name, kind_e k, int idx, logic [31:0] exp);
    sb.push_back('{name, k, idx, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [31:0] obs;
    for (int i = 0; i < 256; i++) dut.imem.memory[i] = 32'hFFFF_FFFF;
    dut.imem.memory[0] = 32'hAC03_0040;
    dut.imem.memory[1] = 32'h8C24_0002;
    dut.imem.memory[2] = 32'h00A6_3820;
    dut.imem.memory[3] = 32'h1509_FFFF;
    dut.imem.memory[4] = 32'h1109_FFFF;
    dut.imem.memory[5] = 32'h0800_0002;
    dut.regFile.registers[0] <= 32'd0;
    dut.regFile.registers[1] <= 32'd5;
    dut.regFile.registers[3] <= 32'h1234;
    dut.regFile.registers[5] <= 32'd3;
    dut.regFile.registers[6] <= 32'hFFFF_FFFF;
    dut.regFile.registers[8] <= 32'd1;
    dut.regFile.registers[9] <= 32'd2;
    dut.dmem.memory[7]  <= 32'hCAFE;
    dut.dmem.memory[64] <= 32'hDEAD;
    rst = 1'b1;
    push("reset_pc", K_PC, 0, 32'd0);
    push("reset_keeps_r3", K_REG, 3, 32'h1234);
    push("reset_no_sw", K_MEM, 64, 32'hDEAD);
    step();
    rst = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.idx);
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_mem();
    sb_t e;
    logic [31:0] obs;
    push("sw_dmem64", K_MEM, 64, 32'h1234);
    push("sw_pc", K_PC, 0, 32'd1);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.idx);
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
    push("lw_r4", K_REG, 4, 32'hCAFE);
    push("lw_pc", K_PC, 0, 32'd2);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.idx);
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_add();
    sb_t e;
    logic [31:0] obs;
    push("add_r7", K_REG, 7, 32'd3 + 32'hFFFF_FFFF);
    push("add_pc", K_PC, 0, 32'd3);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.idx);
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_branch();
    sb_t e;
    logic [31:0] obs;
    logic [31:0] exp_pc [6] = '{32'd3, 32'd3, 32'd4, 32'd4, 32'd4, 32'd5};
    for (int i = 0; i < 6; i++) begin
      if (i == 2) dut.regFile.registers[9] <= 32'd1;
      if (i == 5) dut.regFile.registers[9] <= 32'd2;
      #1;
      push($sformatf("branch_pc_step%0d", i), K_PC, 0, exp_pc[i]);
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_checks++;
        if (obs !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_jump();
    sb_t e;
    logic [31:0] obs;
    push("j_pc", K_PC, 0, 32'd2);
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.kind, e.idx);
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [31:0] obs;
    logic [31:0] prog [10] = '{32'h00A6_5022, 32'h00C5_582A, 32'h00A6_6024,
                               32'h00A6_6825, 32'h00A5_0020, 32'h200E_0007,
                               32'hFC00_0000, 32'hADCD_0000, 32'h8DD0_0000,
                               32'h00A6_7027};
    logic [31:0] a = 32'd3;
    logic [31:0] b = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) dut.imem.memory[8 + i] = prog[i];
    dut.imem.memory[2] = 32'h0800_0008;
    push("j8_pc", K_PC, 0, 32'd8);
    for (int i = 0; i < 11; i++) begin
      case (i)
        1:  push("sub_r10", K_REG, 10, a - b);
        2:  push("slt_r11", K_REG, 11, {31'd0, $signed(b) < $signed(a)});
        3:  push("and_r12", K_REG, 12, a & b);
        4:  push("or_r13", K_REG, 13, a | b);
        5:  push("add_r0_zero", K_REG, 0, 32'd0);
        6:  push("addi_r14", K_REG, 14, 32'd7);
        8:  push("sw_dmem7", K_MEM, 7, a | b);
        9:  push("lw_r16", K_REG, 16, a | b);
        10: push("badfunct_r14", K_REG, 14, 32'd7);
        default: ;
      endcase
      if (i > 0) push($sformatf("seq_pc_%0d", i), K_PC, 0, 32'd8 + 32'(i));
      step();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        obs = observe(e.kind, e.idx);
        n_checks++;
        if (obs !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_add();
    test_branch();
    test_jump();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
